if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage that drives the producer side of the IF→ID pipeline handshake: pc_if, instruction_if, valid_if and ready_go_if.
- Generates sequential PCs and issues requests to instruction memory over a req/gnt + rvalid interface.
- Buffers in-order responses in a 2-entry queue and delivers them to if_id when allow_in_id is high.
- Handles flush/redirect from EX, including discarding in-flight stale responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, instruction queue depth; also the maximum of outstanding requests plus queued entries.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  redirect request from EX.
- redirect_pc  input  BUS_WIDTH  new fetch target; sampled when flush=1.
- hold  input  1  pipeline hold; suppresses new memory requests.
- imem_req  output  1  fetch request valid.
- imem_addr  output  BUS_WIDTH  fetch address; word aligned.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response valid; in order, at least 1 cycle after grant.
- imem_rdata  input  DATA_WIDTH  fetched instruction.
- pc_if  output  BUS_WIDTH  PC of the queue head.
- instruction_if  output  DATA_WIDTH  instruction at the queue head.
- valid_if  output  1  queue non-empty.
- ready_go_if  output  1  head may advance.
- allow_in_id  input  1  if_id can accept.

Behaviour:
- Reset (async) values:
  - fetch_pc=RESET_PC; state=BOOT; queue empty.
  - outstanding=0; discard=0.
  - imem_req=0; valid_if=0; ready_go_if=0.
  - pc_if=0; instruction_if=0.
- FSM states:
  - BOOT: one cycle after reset release with no request issued, then → RUN.
  - RUN: normal fetch operation.
  - DRAIN: flush taken with outstanding>0; no requests until discard==0, then → RUN.
- Request issue: imem_req = (state==RUN) & ~hold & ~flush & (outstanding + count < BUF_DEPTH).
- imem_addr = fetch_pc. On imem_req & imem_gnt: fetch_pc += 4 (wraps mod 2^BUS_WIDTH), and outstanding increments.
- A PC tag queue, parallel to the requests, records imem_addr at grant time.
- Response: imem_rvalid decrements outstanding.
  - If discard>0: the response is dropped and discard decrements.
  - Otherwise {pc tag, imem_rdata} is pushed into the queue.
- Output handshake:
  - valid_if = count≠0; ready_go_if = valid_if.
  - Pop when valid_if & ready_go_if & allow_in_id.
  - Push and pop in the same cycle with the queue full is legal; count is unchanged.
  - Outputs are registered from the queue head and hold their value while not popped.
- Flush (priority over everything else):
  - Queue cleared; fetch_pc = {redirect_pc[BUS_WIDTH-1:2], 2'b00}.
  - discard = outstanding minus any response arriving this same cycle; that response is itself dropped.
  - State → DRAIN if the resulting discard>0, else RUN.
  - No request is issued in the flush cycle.
  - valid_if is not gated combinationally; if_id masks with flush.
- Flush during DRAIN: reload fetch_pc and stay in DRAIN; discard keeps counting the remaining outstanding responses.
- Hold: blocks new requests only. Outstanding responses still fill the queue.
- Errors: imem_rvalid with outstanding==0 is a protocol error; the response is ignored and counters do not underflow.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- With the macro defined:
  - Extra output perf_bubble_cnt [31:0], reset 0.
  - Increments each cycle with allow_in_id & ~valid_if & ~flush & ~hold.
  - Saturates at 32'hFFFF_FFFF.
- Without the macro: the port and the counter are absent.

Decomposition:
- include.v (shared): BUS_WIDTH, DATA_WIDTH, RESET_PC default, FSM state encodings (IF_BOOT, IF_RUN, IF_DRAIN), instruction width constant 4 for the PC step.
- Sub-module if_buffer: parameterised BUF_DEPTH synchronous FIFO of {pc, instruction}.
  - Ports: push, pop, clear, full, empty, count.
  - Same clk/rst_n convention.

Test Plan:
- Boot, 0-wait memory:
  - Stimulus: reset release, imem_gnt=1, rvalid 1 cycle after grant, allow_in_id=1.
  - Response: imem_req first high at cycle 2; pc_if sequence 0x0, 0x4, 0x8 on consecutive cycles.
- Backpressure:
  - Stimulus: allow_in_id=0 for 5 cycles.
  - Response: queue fills to 2, imem_req drops, head stays pc_if=0x4; resumes in order with 0x8 after release.
- Flush with 2 outstanding:
  - Stimulus: flush with redirect_pc=0x103 while 2 responses are in flight.
  - Response: both dropped, state DRAIN for 2 responses, next imem_addr=0x100, next valid pc_if=0x100.
- Flush coincident with rvalid and pop:
  - Response: queue empty next cycle, response dropped, discard = outstanding-1.
- Hold:
  - Stimulus: hold=1 for 3 cycles with 1 outstanding.
  - Response: no imem_req; the outstanding instruction enters the queue; fetch_pc unchanged.
- Async reset mid-DRAIN:
  - Stimulus: assert rst_n low while in DRAIN.
  - Response: all outputs immediately reset values; fetch restarts at RESET_PC.
  - With IF_PERF_CNT_EN defined, also check perf_bubble_cnt reset and increments.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared widths, FSM encoding and queue entry type.
// The optional bubble counter is built when IF_PERF_CNT_EN is defined.
package if_fetch_stage_pkg;

    localparam int BUS_WIDTH  = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [BUS_WIDTH-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [BUS_WIDTH-1:0] INSN_BYTES   = BUS_WIDTH'(4);

    typedef enum logic [1:0] {
        IF_BOOT  = 2'd0,
        IF_RUN   = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [BUS_WIDTH-1:0]  pc;
        logic [DATA_WIDTH-1:0] insn;
    } if_entry_t;

    function automatic logic [BUS_WIDTH-1:0] align_pc(
        input logic [BUS_WIDTH-1:0] pc
    );
        return {pc[BUS_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory bus plus the IF->ID handshake.
// master = fetch stage side, slave = memory / decode side.
interface if_fetch_stage_if;
    import if_fetch_stage_pkg::*;

    logic                  imem_req;
    logic [BUS_WIDTH-1:0]  imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;

    logic [BUS_WIDTH-1:0]  pc_if;
    logic [DATA_WIDTH-1:0] instruction_if;
    logic                  valid_if;
    logic                  ready_go_if;
    logic                  allow_in_id;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output pc_if, instruction_if, valid_if, ready_go_if,
        input  allow_in_id
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  pc_if, instruction_if, valid_if, ready_go_if,
        output allow_in_id
    );

endinterface

// File: rtl/if_fetch_stage_buffer.sv
// if_buffer: small synchronous FIFO with clear; clear beats push/pop.
// A push into a full FIFO is accepted only alongside a pop.
module if_buffer #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);
    assign count = cnt_q;
    assign rdata = mem_q[rd_q];

    // Pointer, occupancy and storage update.
    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        if (clear) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = wdata;
                wr_d        = nxt(wr_q);
            end
            if (do_pop) begin
                rd_d = nxt(rd_q);
            end
            if (do_push & ~do_pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (do_pop & ~do_push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: sequential fetch, in-order response queue, flush/drain.
// Define IF_PERF_CNT_EN to add the perf_bubble_cnt output.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [BUS_WIDTH-1:0] RESET_PC  = RESET_PC_DEF,
    parameter int                   BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [BUS_WIDTH-1:0] redirect_pc,
    input  logic                 hold,
    if_fetch_stage_if.master     bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]          perf_bubble_cnt
`endif
);
    localparam int            CW  = $clog2(BUF_DEPTH + 1);
    localparam int            EW  = BUS_WIDTH + DATA_WIDTH;
    localparam logic [CW:0]   CAP = (CW + 1)'(BUF_DEPTH);

    if_state_e            state_q, state_d;
    logic [BUS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]        discard_q, discard_d;

    logic                 fire, rsp_ok, room;
    logic                 q_push, q_pop, q_clear;
    logic                 q_full, q_empty, t_full, t_empty;
    logic [CW-1:0]        q_cnt, outst;
    logic [BUS_WIDTH-1:0] t_head;
    logic [EW-1:0]        q_rdata;
    if_entry_t            q_head, q_wdata;
    logic                 unused_ok;

    assign room          = ({1'b0, outst} + {1'b0, q_cnt}) < CAP;
    assign bus.imem_req  = (state_q == IF_RUN) & ~hold & ~flush & room;
    assign bus.imem_addr = fetch_pc_q;
    assign fire          = bus.imem_req & bus.imem_gnt;
    assign rsp_ok        = bus.imem_rvalid & ~t_empty;

    assign q_wdata            = '{pc: t_head, insn: bus.imem_rdata};
    assign q_head             = if_entry_t'(q_rdata);
    assign bus.valid_if       = ~q_empty;
    assign bus.ready_go_if    = bus.valid_if;
    assign bus.pc_if          = q_head.pc;
    assign bus.instruction_if = q_head.insn;
    assign q_pop = bus.valid_if & bus.ready_go_if & bus.allow_in_id;
    assign unused_ok = &{1'b0, q_full, t_full};

    // Tag FIFO: one PC per granted request; its count is outstanding.
    if_buffer #(.DEPTH(BUF_DEPTH), .W(BUS_WIDTH)) u_tags (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fire),
        .pop   (rsp_ok),
        .clear (1'b0),
        .wdata (fetch_pc_q),
        .rdata (t_head),
        .full  (t_full),
        .empty (t_empty),
        .count (outst)
    );

    if_buffer #(.DEPTH(BUF_DEPTH), .W(EW)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .pop   (q_pop),
        .clear (q_clear),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_cnt)
    );

    // Next fetch PC, FSM and stale-response accounting.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        q_push     = 1'b0;
        q_clear    = 1'b0;
        if (flush) begin
            q_clear    = 1'b1;
            fetch_pc_d = align_pc(redirect_pc);
            discard_d  = rsp_ok ? outst - 1'b1 : outst;
            state_d    = (discard_d != '0) ? IF_DRAIN : IF_RUN;
        end else begin
            if (fire) begin
                fetch_pc_d = fetch_pc_q + INSN_BYTES;
            end
            if (rsp_ok) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - 1'b1;
                end else begin
                    q_push = 1'b1;
                end
            end
            unique case (state_q)
                IF_BOOT:  state_d = IF_RUN;
                IF_DRAIN: if (discard_d == '0) state_d = IF_RUN;
                default:  state_d = state_q;
            endcase
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IF_BOOT;
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt_q, perf_bubble_cnt_d;
    logic        bubble;

    assign bubble = bus.allow_in_id & ~bus.valid_if & ~flush & ~hold;
    assign perf_bubble_cnt = perf_bubble_cnt_q;

    // Saturating count of decode slots left idle by an empty queue.
    always_comb begin
        perf_bubble_cnt_d = perf_bubble_cnt_q;
        if (bubble && perf_bubble_cnt_q != 32'hFFFF_FFFF) begin
            perf_bubble_cnt_d = perf_bubble_cnt_q + 32'd1;
        end
    end

    // Bubble counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubble_cnt_q <= '0;
        end else begin
            perf_bubble_cnt_q <= perf_bubble_cnt_d;
        end
    end
`endif

endmodule
